quad_phase_cdr: RTL

- 4x-oversampling clock/data recovery stage that sits directly downstream of the four-phase rotating shift register (phase0/90/180/270, period 4 clk).
- Decodes the phase word into a slot index 0..3 and samples serial rx_in every clk.
- Votes on which slot carries data transitions, then emits one recovered bit per 4-clk bit period from the slot opposite the edge (edge slot + 2).

---
 rtl/quad_phase_cdr_pkg.sv | 27 ++
 rtl/qpc_phase_decode.sv | 23 ++
 rtl/quad_phase_cdr.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/quad_phase_cdr_pkg.sv
// Shared types and constants for the quad-phase clock/data recovery block.
package quad_phase_cdr_pkg;

    // Sample slot within one 4-clk bit period.
    typedef logic [1:0] slot_t;

    // Legal phase words, ordered {phase0, phase90, phase180, phase270}.
    localparam logic [3:0] PH_SLOT0 = 4'b1100;
    localparam logic [3:0] PH_SLOT1 = 4'b0110;
    localparam logic [3:0] PH_SLOT2 = 4'b0011;
    localparam logic [3:0] PH_SLOT3 = 4'b1001;

    // Recovery state: hunting for the edge slot, or emitting bits.
    typedef enum logic [0:0] {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } cdr_state_t;

    localparam int LOCK_THRESH_DEF = 8;
    localparam int CNT_W_DEF       = 4;

    // The data eye centre sits half a bit period away from the edge slot.
    function automatic slot_t slot_opposite(input slot_t s);
        return slot_t'(s + 2'd2);
    endfunction

endpackage

// File: rtl/qpc_phase_decode.sv
// Maps the rotating four-phase word onto a slot index and flags illegal words.
module qpc_phase_decode
    import quad_phase_cdr_pkg::*;
(
    input  logic [3:0] phase_word_i,
    output slot_t      slot_o,
    output logic       legal_o
);

    // Only the four one-hot-pair rotations are legal; anything else is a glitch.
    always_comb begin
        slot_o  = 2'd0;
        legal_o = 1'b1;
        case (phase_word_i)
            PH_SLOT0: slot_o = 2'd0;
            PH_SLOT1: slot_o = 2'd1;
            PH_SLOT2: slot_o = 2'd2;
            PH_SLOT3: slot_o = 2'd3;
            default:  legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/quad_phase_cdr.sv
// 4x-oversampling CDR: votes on the slot that carries data transitions and
// emits one recovered bit per bit period from the slot opposite the edge.
module quad_phase_cdr
    import quad_phase_cdr_pkg::*;
#(
    parameter int LOCK_THRESH = LOCK_THRESH_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       init,
    input  logic       phase0,
    input  logic       phase90,
    input  logic       phase180,
    input  logic       phase270,
    input  logic       rx_in,
    output logic       bit_valid,
    output logic       bit_data,
    output logic       locked,
    output logic [1:0] sample_slot,
    output logic       phase_err
);

    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(LOCK_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Phase decode (combinational, on the raw phase inputs)
    // ------------------------------------------------------------------
    slot_t slot_raw;
    logic  legal_raw;

    qpc_phase_decode u_decode (
        .phase_word_i ({phase0, phase90, phase180, phase270}),
        .slot_o       (slot_raw),
        .legal_o      (legal_raw)
    );

    // ------------------------------------------------------------------
    // Synchroniser and matching phase delay line
    // ------------------------------------------------------------------
    logic       rx_meta_q;
    logic       rx_s_q;
    logic       rx_prev_q;
    slot_t      slot_d1_q;
    slot_t      slot_a_q;
    logic       legal_d1_q;
    logic       legal_a_q;
    // vld_pipe_q[1]: aligned stage holds a real post-reset sample.
    // vld_pipe_q[2]: rx_prev_q also holds a real sample, so edges are meaningful.
    logic [2:0] vld_pipe_q;

    // Two-flop synchroniser for rx_in; slot/legal ride two flops alongside it.
    always_ff @(posedge clk) begin
        if (init) begin
            rx_meta_q  <= 1'b0;
            rx_s_q     <= 1'b0;
            rx_prev_q  <= 1'b0;
            slot_d1_q  <= 2'd0;
            slot_a_q   <= 2'd0;
            legal_d1_q <= 1'b0;
            legal_a_q  <= 1'b0;
            vld_pipe_q <= 3'b000;
        end else begin
            rx_meta_q  <= rx_in;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            slot_d1_q  <= slot_raw;
            slot_a_q   <= slot_d1_q;
            legal_d1_q <= legal_raw;
            legal_a_q  <= legal_d1_q;
            vld_pipe_q <= {vld_pipe_q[1:0], 1'b1};
        end
    end

    logic act_w;
    logic edge_w;

    // The reset values still flushing through the delay line must neither
    // look like an illegal phase word nor fabricate an edge.
    assign act_w  = vld_pipe_q[1];
    assign edge_w = vld_pipe_q[2] && (rx_s_q != rx_prev_q);

    // ------------------------------------------------------------------
    // Voting, FSM and output register
    // ------------------------------------------------------------------
    logic [3:0][CNT_W-1:0] cnt_q,   cnt_d;
    cdr_state_t            state_q, state_d;
    slot_t                 sample_slot_q, sample_slot_d;
    logic                  bit_valid_q,   bit_valid_d;
    logic                  bit_data_q,    bit_data_d;
    logic                  phase_err_q,   phase_err_d;
    logic [CNT_W-1:0]      cnt_inc;

    // Saturating increment of the counter belonging to the aligned slot.
    always_comb begin
        cnt_inc = cnt_q[slot_a_q];
        if (cnt_q[slot_a_q] != CNT_MAX) begin
            cnt_inc = cnt_q[slot_a_q] + CNT_ONE;
        end
    end

    // Next-state: illegal-phase recovery, bit emission, then edge voting.
    always_comb begin
        cnt_d         = cnt_q;
        state_d       = state_q;
        sample_slot_d = sample_slot_q;
        bit_valid_d   = 1'b0;
        bit_data_d    = bit_data_q;
        phase_err_d   = 1'b0;

        if (act_w) begin
            if (!legal_a_q) begin
                // Phase generator glitched: distrust all votes and relock.
                // sample_slot keeps its last value for visibility.
                phase_err_d = 1'b1;
                cnt_d       = '0;
                state_d     = ACQUIRE;
            end else begin
                // Emission uses the sample slot in force before any
                // re-selection made by this same edge.
                if ((state_q == LOCKED) && (slot_a_q == sample_slot_q)) begin
                    bit_valid_d = 1'b1;
                    bit_data_d  = rx_s_q;
                end

                if (edge_w) begin
                    if (cnt_inc == THRESH) begin
                        // Adopt this slot as the edge slot; the winning edge
                        // is consumed by the clear so every slot starts fresh.
                        cnt_d         = '0;
                        sample_slot_d = slot_opposite(slot_a_q);
                        state_d       = LOCKED;
                    end else begin
                        cnt_d[slot_a_q] = cnt_inc;
                    end
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (init) begin
            cnt_q         <= '0;
            state_q       <= ACQUIRE;
            sample_slot_q <= 2'd0;
            bit_valid_q   <= 1'b0;
            bit_data_q    <= 1'b0;
            phase_err_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            sample_slot_q <= sample_slot_d;
            bit_valid_q   <= bit_valid_d;
            bit_data_q    <= bit_data_d;
            phase_err_q   <= phase_err_d;
        end
    end

    assign bit_valid   = bit_valid_q;
    assign bit_data    = bit_data_q;
    assign locked      = (state_q == LOCKED);
    assign sample_slot = sample_slot_q;
    assign phase_err   = phase_err_q;

endmodule
